// File: rtl/theremin_audio_pkg.sv
// rtl/theremin_audio_pkg.sv - shared types and constants for the theremin audio output stage
package theremin_audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    PAD
  } ser_state_t;

  localparam int I2S_DELAY_SLOTS = 1;
  localparam int SYNC_STAGES     = 2;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock sample buffer with registered ready
module sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;
  logic              ready_q;
  logic              push;
  logic              pop;

  assign push    = wr_valid & ready_q;
  assign pop     = rd_en & (count_q != '0);
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

  assign wr_ready = ready_q;
  assign rd_data  = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);

  // Ready follows the next-state count so a push can never land on a full buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// rtl/i2s_dac_serializer.sv - I2S mono-to-stereo DAC serializer; DAC_HOLD_ON_UNDERFLOW_EN holds last sample on underflow
module i2s_dac_serializer
  import theremin_audio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              bclk,
  input  logic              daclrc,
  output logic              dacdat,
  output logic              underflow,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W);

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrc_sync_q;
  logic                   bclk_prev_q;
  logic                   lrc_q;
  logic                   bclk_s;
  logic                   lrc_s;
  logic                   tick;
  logic                   lrc_edge;

  ser_state_t        state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic              dacdat_q, dacdat_d;
  logic              underflow_q, underflow_d;
  logic              frame_err_q, frame_err_d;
  logic              start;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_data  (sample_data),
    .wr_valid (sample_valid),
    .wr_ready (sample_ready),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .empty    (fifo_empty)
  );

  assign bclk_s   = bclk_sync_q[SYNC_STAGES-1];
  assign lrc_s    = lrc_sync_q[SYNC_STAGES-1];
  assign tick     = bclk_prev_q & ~bclk_s;
  assign lrc_edge = (lrc_s != lrc_q);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    dacdat_d    = dacdat_q;
    underflow_d = 1'b0;
    frame_err_d = 1'b0;
    start       = 1'b0;
    pop         = 1'b0;
    if (tick) begin
      dacdat_d = 1'b0;
      case (state_q)
        IDLE:  start = lrc_edge & ~lrc_s;
        DELAY: begin
          state_d   = SHIFT;
          bit_cnt_d = CW'(DATA_W - 1);
          dacdat_d  = frame_q[DATA_W-1];
        end
        SHIFT: begin
          if (lrc_edge) begin
            // Bit 0 already presented means the word completed exactly on the boundary.
            frame_err_d = (bit_cnt_q != '0);
            start       = 1'b1;
          end else if (bit_cnt_q == '0) begin
            state_d = PAD;
          end else begin
            bit_cnt_d = bit_cnt_q - CW'(1);
            dacdat_d  = frame_q[bit_cnt_q - CW'(1)];
          end
        end
        PAD:     start = lrc_edge;
        default: state_d = IDLE;
      endcase
      if (start) begin
        state_d = DELAY;
        if (!lrc_s) begin
          pop = 1'b1;
          if (fifo_empty) begin
            underflow_d = 1'b1;
`ifdef DAC_HOLD_ON_UNDERFLOW_EN
            frame_d = frame_q;
`else
            frame_d = '0;
`endif
          end else begin
            frame_d = fifo_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q <= '0;
      lrc_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrc_q       <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrc_sync_q  <= {lrc_sync_q[SYNC_STAGES-2:0], daclrc};
      bclk_prev_q <= bclk_s;
      if (tick) lrc_q <= lrc_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      dacdat_q    <= dacdat_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign dacdat    = dacdat_q;
  assign underflow = underflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb/tb_i2s_dac_serializer.sv - scoreboard bench: codec-side bclk/daclrc driver with per-channel capture
module tb_i2s_dac_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        bclk;
  logic        daclrc;
  logic        dacdat;
  logic        underflow;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int uf_cnt = 0;
  int fe_cnt = 0;
  int chan_idx = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_word;
  logic [63:0] mon_cap;
  int          mon_n = 0;
  logic        mon_lrc;
  bit          mon_en = 1'b0;

  logic [15:0] words [6] = '{16'h1111, 16'h8F0E, 16'h7001, 16'hC3A5, 16'h0FF0, 16'h5A5A};

  always #5 clk = ~clk;

  i2s_dac_serializer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .daclrc       (daclrc),
    .dacdat       (dacdat),
    .underflow    (underflow),
    .frame_err    (frame_err)
  );

  always @(negedge clk) begin
    if (underflow) uf_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Slot k of a channel: k=0 is the I2S delay slot, k=1..16 carry bits 15..0.
  function automatic logic [63:0] exp_bits(input int len, input logic [15:0] w);
    logic [63:0] e = '0;
    for (int k = 1; k <= 16; k++)
      if (k < len) e[k] = w[16-k];
    return e;
  endfunction

  always @(posedge bclk) begin
    if (mon_en) begin
      if (daclrc !== mon_lrc) begin
        if (mon_n > 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL chan%0d unexpected channel got %0h expected none", chan_idx, mon_cap);
          end else begin
            exp_word = exp_q.pop_front();
            check($sformatf("chan%0d", chan_idx), mon_cap, exp_word);
          end
          chan_idx++;
        end
        mon_cap = '0;
        mon_n   = 0;
        mon_lrc = daclrc;
      end
      if (mon_n < 64) mon_cap[mon_n] = dacdat;
      mon_n++;
    end
  end

  task automatic push(input logic [15:0] w);
    int t = 0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = w;
    while (!sample_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!sample_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got ready=0 required ready=1 for %h", w);
    end
    @(posedge clk);
  endtask

  task automatic idle_valid();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic run_chan(input logic lrc, input int len, input logic [63:0] exp,
                          input bit do_exp, input int rst_slot);
    if (do_exp) exp_q.push_back(exp);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      bclk = 1'b0;
      if (k == 0) daclrc = lrc;
      if (k == rst_slot) begin
        repeat (6) @(negedge clk);
        check("pre_rst_dacdat", dacdat, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_dacdat", dacdat, 0);
        check("rst_mid_ready", sample_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      bclk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    bclk         = 1'b1;
    daclrc       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dacdat", dacdat, 0);
    check("rst_underflow", underflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_ready", sample_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", sample_ready, 1);
    mon_en = 1'b1;

    // Starting in a right channel: silent, and the queued sample stays queued.
    push(16'hA5C3);
    idle_valid();
    run_chan(1'b1, 32, 64'h0, 1'b1, -1);

    run_chan(1'b0, 32, exp_bits(32, 16'hA5C3), 1'b1, -1);
    run_chan(1'b1, 32, exp_bits(32, 16'hA5C3), 1'b1, -1);
    check("uf_after_t1", uf_cnt, 0);

    repeat (3) begin
      run_chan(1'b0, 18, 64'h0, 1'b1, -1);
      run_chan(1'b1, 18, 64'h0, 1'b1, -1);
    end
    check("uf_after_t2", uf_cnt, 3);

    for (int i = 0; i < 4; i++) push(words[i]);
    idle_valid();
    check("ready_full", sample_ready, 0);
    fork
      begin
        push(words[4]);
        push(words[5]);
        idle_valid();
      end
    join_none
    for (int i = 0; i < 6; i++) begin
      run_chan(1'b0, 18, exp_bits(18, words[i]), 1'b1, -1);
      run_chan(1'b1, 18, exp_bits(18, words[i]), 1'b1, -1);
    end
    check("ready_drained", sample_ready, 1);
    check("fe_before_t4", fe_cnt, 0);

    push(16'h3C5A);
    idle_valid();
    run_chan(1'b0, 10, exp_bits(10, 16'h3C5A), 1'b1, -1);
    run_chan(1'b1, 18, exp_bits(18, 16'h3C5A), 1'b1, -1);
    check("fe_after_t4", fe_cnt, 1);

    push(16'hA5C3);
    idle_valid();
    run_chan(1'b0, 18, exp_bits(18, 16'hA5C3) & 64'h1FF, 1'b1, 9);
    push(16'h1234);
    idle_valid();
    run_chan(1'b1, 18, 64'h0, 1'b1, -1);
    run_chan(1'b0, 18, exp_bits(18, 16'h1234), 1'b1, -1);
    run_chan(1'b1, 18, exp_bits(18, 16'h1234), 1'b1, -1);
    check("uf_final", uf_cnt, 3);
    check("fe_final", fe_cnt, 1);

    run_chan(1'b0, 1, 64'h0, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
